// File: rtl/raifes_gpio_debounce_pkg.sv
// Shared defaults and types for the GPIO input conditioner.
// The per-bit slice reports its state through one packed struct.
package raifes_gpio_debounce_pkg;

  localparam int unsigned GPIO_WIDTH                = 8;
  localparam int unsigned GPIO_DEBOUNCE_DEFAULT     = 16;
  localparam int unsigned GPIO_SYNC_STAGES_DEFAULT  = 2;

  // Per-bit status. All fields except update are registered.
  // update is the combinational "accept new level on this edge" strobe.
  typedef struct packed {
    logic sync_s;
    logic update;
    logic stable;
    logic rise;
    logic fall;
  } gpio_bit_evt_t;

  function automatic int cnt_width(input int unsigned cycles);
    return $clog2(cycles) + 1;
  endfunction

endpackage

// File: rtl/raifes_gpio_debounce_bit.sv
// One GPIO input bit: synchroniser chain, stability counter, stable level
// register and one-cycle rise/fall pulses.
module raifes_gpio_debounce_bit
  import raifes_gpio_debounce_pkg::*;
#(
  parameter int unsigned SYNC_STAGES     = GPIO_SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          pad_i,
  output gpio_bit_evt_t evt_o
);

  localparam int CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic                   stable_q, stable_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic                   sync_s;
  logic                   update;

  assign sync_s = sync_q[SYNC_STAGES-1];

  always_comb begin
    sync_d   = {sync_q[SYNC_STAGES-2:0], pad_i};
    cnt_d    = cnt_q;
    stable_d = stable_q;
    update   = 1'b0;
    // The counter only runs while the synchronised level disagrees with the
    // accepted level; any return to agreement restarts the qualification.
    if (sync_s == stable_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      cnt_d    = '0;
      stable_d = sync_s;
      update   = 1'b1;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
    rise_d = update & sync_s;
    fall_d = update & ~sync_s;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q   <= {SYNC_STAGES{RESET_LEVEL}};
      cnt_q    <= '0;
      stable_q <= RESET_LEVEL;
      rise_q   <= 1'b0;
      fall_q   <= 1'b0;
    end else begin
      sync_q   <= sync_d;
      cnt_q    <= cnt_d;
      stable_q <= stable_d;
      rise_q   <= rise_d;
      fall_q   <= fall_d;
    end
  end

  assign evt_o = '{sync_s: sync_s, update: update, stable: stable_q,
                   rise: rise_q, fall: fall_q};

endmodule

// File: rtl/raifes_gpio_debounce.sv
// GPIO input conditioner: per-bit debounce slices plus the sticky pending
// register and the level interrupt toward the core.
module raifes_gpio_debounce
  import raifes_gpio_debounce_pkg::*;
#(
  parameter int unsigned WIDTH           = GPIO_WIDTH,
  parameter int unsigned SYNC_STAGES     = GPIO_SYNC_STAGES_DEFAULT,
  parameter int unsigned DEBOUNCE_CYCLES = GPIO_DEBOUNCE_DEFAULT,
  parameter logic        RESET_LEVEL     = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] pad_i,
  output logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] rise_o,
  output logic [WIDTH-1:0] fall_o,
  input  logic [WIDTH-1:0] irq_rise_en_i,
  input  logic [WIDTH-1:0] irq_fall_en_i,
  input  logic [WIDTH-1:0] irq_clr_i,
  output logic [WIDTH-1:0] pending_o,
  output logic             irq_o
);

  logic [WIDTH-1:0] update, sync_s;
  logic [WIDTH-1:0] pending_q, pending_d, pend_set;

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    gpio_bit_evt_t evt;

    raifes_gpio_debounce_bit #(
      .SYNC_STAGES    (SYNC_STAGES),
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .RESET_LEVEL    (RESET_LEVEL)
    ) u_bit (
      .clk  (clk),
      .reset(reset),
      .pad_i(pad_i[i]),
      .evt_o(evt)
    );

    assign update[i] = evt.update;
    assign sync_s[i] = evt.sync_s;
    assign gpio_i[i] = evt.stable;
    assign rise_o[i] = evt.rise;
    assign fall_o[i] = evt.fall;
  end

  // A new edge on the same cycle as a clear keeps the flag set.
  always_comb begin
    pend_set  = (update & sync_s & irq_rise_en_i) |
                (update & ~sync_s & irq_fall_en_i);
    pending_d = pend_set | (pending_q & ~irq_clr_i);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
    end
  end

  assign pending_o = pending_q;
  assign irq_o     = |pending_q;

endmodule

// File: tb/tb_raifes_gpio_debounce.sv
// Directed bench for raifes_gpio_debounce with a window-based reference model
// checked every cycle and literal checkpoints for each scenario.
module tb_raifes_gpio_debounce;

  localparam int W  = 8;
  localparam int S  = 2;
  localparam int D  = 16;
  localparam logic RL = 1'b0;

  logic         clk = 1'b0;
  logic         reset;
  logic [W-1:0] pad_i, irq_rise_en_i, irq_fall_en_i, irq_clr_i;
  logic [W-1:0] gpio_i, rise_o, fall_o, pending_o;
  logic         irq_o;

  int checks   = 0;
  int failures = 0;

  raifes_gpio_debounce #(
    .WIDTH(W), .SYNC_STAGES(S), .DEBOUNCE_CYCLES(D), .RESET_LEVEL(RL)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .pad_i        (pad_i),
    .gpio_i       (gpio_i),
    .rise_o       (rise_o),
    .fall_o       (fall_o),
    .irq_rise_en_i(irq_rise_en_i),
    .irq_fall_en_i(irq_fall_en_i),
    .irq_clr_i    (irq_clr_i),
    .pending_o    (pending_o),
    .irq_o        (irq_o)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  // Pad samples reach the debouncer S edges later; a new level is accepted
  // once the last D samples seen by the debouncer all differ from the
  // accepted level.
  logic [W-1:0] m_pipe [S];
  logic [W-1:0] m_hist [D];
  logic [W-1:0] m_stable, m_rise, m_fall, m_pend;
  bit           m_valid = 1'b0;

  always @(posedge clk) begin
    logic [W-1:0] s, upd;
    if (reset) begin
      for (int k = 0; k < S; k++) m_pipe[k] = {W{RL}};
      for (int k = 0; k < D; k++) m_hist[k] = {W{RL}};
      m_stable = {W{RL}};
      m_rise   = '0;
      m_fall   = '0;
      m_pend   = '0;
      m_valid  = 1'b1;
    end else if (m_valid) begin
      s = m_pipe[S-1];
      for (int k = D-1; k > 0; k--) m_hist[k] = m_hist[k-1];
      m_hist[0] = s;
      for (int b = 0; b < W; b++) begin
        upd[b] = 1'b1;
        for (int k = 0; k < D; k++)
          if (m_hist[k][b] == m_stable[b]) upd[b] = 1'b0;
      end
      m_rise   = upd & s;
      m_fall   = upd & ~s;
      m_pend   = (m_rise & irq_rise_en_i) | (m_fall & irq_fall_en_i) |
                 (m_pend & ~irq_clr_i);
      m_stable = (m_stable & ~upd) | (s & upd);
      for (int k = S-1; k > 0; k--) m_pipe[k] = m_pipe[k-1];
      m_pipe[0] = pad_i;
    end
  end

  // ---------------- scoreboard ----------------
  task automatic check8(input string name, input logic [W-1:0] got,
                        input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", name, got, exp, $time);
    end
  endtask

  always @(posedge clk) begin
    #1;
    if (m_valid) begin
      check8("cyc_gpio_i", gpio_i, m_stable);
      check8("cyc_rise_o", rise_o, m_rise);
      check8("cyc_fall_o", fall_o, m_fall);
      check8("cyc_pending_o", pending_o, m_pend);
      check8("cyc_irq_o", {7'b0, irq_o}, {7'b0, |m_pend});
    end
  end

  // ---------------- driver tasks ----------------
  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive_pad(input logic [W-1:0] v);
    @(negedge clk);
    pad_i = v;
  endtask

  task automatic pulse_clr(input logic [W-1:0] v);
    @(negedge clk);
    irq_clr_i = v;
    @(negedge clk);
    irq_clr_i = '0;
  endtask

  // Counts edges from the current point until gpio_i[bit] reaches lvl.
  task automatic edges_until(input int bit_idx, input logic lvl, output int n);
    n = 0;
    while (gpio_i[bit_idx] !== lvl && n < 100) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (gpio_i[bit_idx] !== lvl) begin
      checks++;
      failures++;
      $display("FAIL timeout bit %0d waiting for level %0b", bit_idx, lvl);
    end
  endtask

  // ---------------- directed stimulus ----------------
  initial begin
    int n;
    reset = 1'b1;
    pad_i = '0;
    irq_rise_en_i = '0;
    irq_fall_en_i = '0;
    irq_clr_i = '0;
    idle(3);
    check8("reset_gpio_i", gpio_i, 8'h00);
    check8("reset_pending_o", pending_o, 8'h00);
    @(negedge clk);
    reset = 1'b0;

    // Latency of a single rising bit.
    idle(4);
    drive_pad(8'h01);
    edges_until(0, 1'b1, n);
    check8("latency_edges", 8'(n), 8'd18);
    check8("latency_gpio_i", gpio_i, 8'h01);
    check8("latency_rise_o", rise_o, 8'h01);
    check8("latency_fall_o", fall_o, 8'h00);
    idle(1);
    check8("rise_one_cycle", rise_o, 8'h00);

    // Glitch shorter than the debounce window.
    drive_pad(8'h09);
    repeat (9) @(negedge clk);
    pad_i = 8'h01;
    idle(40);
    check8("glitch_gpio_i", gpio_i, 8'h01);
    check8("glitch_pending_o", pending_o, 8'h00);

    // Rising edge sets pending; the later fall does not.
    irq_rise_en_i = 8'hFF;
    drive_pad(8'h05);
    idle(25);
    check8("rise_pending_o", pending_o, 8'h04);
    check8("rise_irq_o", {7'b0, irq_o}, 8'h01);
    drive_pad(8'h01);
    idle(25);
    check8("fall_gpio_i", gpio_i, 8'h01);
    check8("fall_pending_kept", pending_o, 8'h04);
    pulse_clr(8'h04);
    #1;
    check8("clr_pending_o", pending_o, 8'h00);
    check8("clr_irq_o", {7'b0, irq_o}, 8'h00);

    // Update and clear on bit 5 in the same cycle.
    drive_pad(8'h21);
    repeat (17) @(posedge clk);
    @(negedge clk);
    irq_clr_i = 8'h20;
    @(posedge clk);
    #1;
    check8("setwins_gpio_i", gpio_i, 8'h21);
    check8("setwins_pending_o", pending_o, 8'h20);
    @(negedge clk);
    irq_clr_i = 8'h00;

    // All bits falling, then A5 with both enables.
    drive_pad(8'h00);
    idle(25);
    pulse_clr(8'hFF);
    irq_rise_en_i = 8'hFF;
    irq_fall_en_i = 8'hFF;
    drive_pad(8'hA5);
    edges_until(0, 1'b1, n);
    check8("multi_edges", 8'(n), 8'd18);
    check8("multi_gpio_i", gpio_i, 8'hA5);
    check8("multi_rise_o", rise_o, 8'hA5);
    check8("multi_pending_o", pending_o, 8'hA5);
    idle(1);
    check8("multi_rise_done", rise_o, 8'h00);

    // Reset in the middle of a debounce.
    drive_pad(8'h00);
    idle(25);
    pulse_clr(8'hFF);
    drive_pad(8'h01);
    repeat (12) @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    idle(2);
    check8("midreset_gpio_i", gpio_i, 8'h00);
    check8("midreset_pending_o", pending_o, 8'h00);
    @(negedge clk);
    reset = 1'b0;
    edges_until(0, 1'b1, n);
    check8("post_reset_edges", 8'(n), 8'd18);
    check8("post_reset_rise_o", rise_o, 8'h01);
    check8("post_reset_pending_o", pending_o, 8'h01);
    idle(3);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
